timer_ctrl: RTL and testbench



---
 rtl/timer_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : timer_ctrl
// Brief   : Egg-timer sequencer: key edge detect, 1 s prescaler, BCD MM:SS
//           countdown and IDLE/RUN/PAUSE/ALARM control with alarm blink.
//           Optional macro ALARM_TIMEOUT_EN adds automatic alarm clearing.
// Revision: 1.0 - initial release
// ============================================================================
module timer_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int ALARM_SECS = 30
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  KEY_N,
    input  logic [7:0]  SW,
    output logic [15:0] TIME_BCD,
    output logic        RUNNING,
    output logic        PAUSED,
    output logic        ALARM,
    output logic        BLINK
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [1:0] c_ALARM = 2'd3;

    localparam int              c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);

    logic [1:0]      key_s1_q, key_s2_q, key_s3_q;
    logic [1:0]      w_press;
    logic            w_start, w_cancel;
    logic [1:0]      state_q, state_d;
    logic [c_PW-1:0] presc_q, presc_d;
    logic            w_tick;
    logic [15:0]     time_q, time_d, w_time_dec;
    logic [3:0]      w_load_m10, w_load_m1;
    logic            w_load_zero;
    logic            w_alarm_expire;
    logic            blink_q, blink_d;
    logic            running_q, running_d;
    logic            paused_q, paused_d;
    logic            alarm_q, alarm_d;

    // Keys are active-low: a press is the first cycle s2 sees 0 while s3 still holds 1
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            key_s3_q <= 2'b11;
        end else begin
            key_s1_q <= KEY_N;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
        end
    end

    assign w_press  = key_s3_q & ~key_s2_q;
    assign w_cancel = w_press[1];
    assign w_start  = w_press[0] & ~w_press[1];

    assign w_tick = ((state_q == c_RUN) || (state_q == c_ALARM)) && (presc_q == c_PRESC_MAX);

    assign w_load_m10  = (SW[7:4] > 4'd9) ? 4'd9 : SW[7:4];
    assign w_load_m1   = (SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];
    assign w_load_zero = (w_load_m10 == 4'd0) && (w_load_m1 == 4'd0);

    always_comb begin
        w_time_dec = time_q;
        if (time_q[3:0] != 4'd0) begin
            w_time_dec[3:0] = time_q[3:0] - 4'd1;
        end else begin
            w_time_dec[3:0] = 4'd9;
            if (time_q[7:4] != 4'd0) begin
                w_time_dec[7:4] = time_q[7:4] - 4'd1;
            end else begin
                w_time_dec[7:4] = 4'd5;
                if (time_q[11:8] != 4'd0) begin
                    w_time_dec[11:8] = time_q[11:8] - 4'd1;
                end else begin
                    w_time_dec[11:8]  = 4'd9;
                    w_time_dec[15:12] = time_q[15:12] - 4'd1;
                end
            end
        end
    end

`ifdef ALARM_TIMEOUT_EN
    localparam int c_AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;

    logic [c_AW-1:0] acnt_q, acnt_d;

    assign w_alarm_expire = w_tick && (state_q == c_ALARM) && (acnt_q == c_AW'(ALARM_SECS - 1));

    always_comb begin
        acnt_d = '0;
        if ((state_q == c_ALARM) && (state_d == c_ALARM)) begin
            acnt_d = w_tick ? (acnt_q + c_AW'(1)) : acnt_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acnt_q <= '0;
        end else begin
            acnt_q <= acnt_d;
        end
    end
`else
    localparam int c_unused_alarm_secs = ALARM_SECS;

    assign w_alarm_expire = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (!w_cancel && w_start && !w_load_zero) begin
                    state_d = c_RUN;
                end
            end
            c_RUN: begin
                if (w_cancel) begin
                    state_d = c_IDLE;
                end else if (w_tick && (time_q == 16'h0001)) begin
                    state_d = c_ALARM;
                end else if (w_start) begin
                    state_d = c_PAUSE;
                end
            end
            c_PAUSE: begin
                if (w_cancel) begin
                    state_d = c_IDLE;
                end else if (w_start) begin
                    state_d = c_RUN;
                end
            end
            c_ALARM: begin
                if (w_cancel || w_start || w_alarm_expire) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Leaving or entering a counting state restarts the prescaler from 0
    always_comb begin
        presc_d = '0;
        if (((state_q == c_RUN) || (state_q == c_ALARM)) && (state_d == state_q)) begin
            presc_d = w_tick ? '0 : (presc_q + c_PW'(1));
        end

        time_d = time_q;
        if (state_d == c_IDLE) begin
            time_d = 16'h0000;
        end else if ((state_q == c_IDLE) && (state_d == c_RUN)) begin
            time_d = {w_load_m10, w_load_m1, 8'h00};
        end else if ((state_q == c_RUN) && w_tick) begin
            time_d = w_time_dec;
        end

        blink_d = 1'b0;
        if (state_d == c_ALARM) begin
            if (state_q != c_ALARM) begin
                blink_d = 1'b1;
            end else begin
                blink_d = w_tick ? ~blink_q : blink_q;
            end
        end

        running_d = (state_d == c_RUN);
        paused_d  = (state_d == c_PAUSE);
        alarm_d   = (state_d == c_ALARM);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q   <= '0;
            time_q    <= 16'h0000;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            time_q    <= time_d;
            blink_q   <= blink_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            alarm_q   <= alarm_d;
        end
    end

    assign TIME_BCD = time_q;
    assign RUNNING  = running_q;
    assign PAUSED   = paused_q;
    assign ALARM    = alarm_q;
    assign BLINK    = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_ctrl
// Brief   : Directed self-checking bench for timer_ctrl (TICK_DIV = 10).
// Revision: 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic [1:0]  KEY_N;
    logic [7:0]  SW;
    logic [15:0] TIME_BCD;
    logic        RUNNING;
    logic        PAUSED;
    logic        ALARM;
    logic        BLINK;

    int vectors;
    int miscompares;

    timer_ctrl #(
        .TICK_DIV   (10),
        .ALARM_SECS (3)
    ) u_dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_N),
        .SW       (SW),
        .TIME_BCD (TIME_BCD),
        .RUNNING  (RUNNING),
        .PAUSED   (PAUSED),
        .ALARM    (ALARM),
        .BLINK    (BLINK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Key goes low on a falling edge; the FSM acts on the third rising edge,
    // so the task returns on the falling edge right after that action.
    task automatic press(input int b);
        @(negedge CLK);
        KEY_N[b] = 1'b0;
        repeat (3) @(negedge CLK);
        KEY_N[b] = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        KEY_N   = 2'b11;
        SW      = 8'h00;
        #2;
        vectors++;
        if ({TIME_BCD, RUNNING, PAUSED, ALARM, BLINK} !== 20'h0_0000) begin
            miscompares++;
            $display("FAIL reset_state got %h/%b exp 0000/0000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_async_reset();
        SW = 8'h05;
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h0500 || RUNNING !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre got %h run=%b exp 0500 run=1", TIME_BCD, RUNNING);
        end
        repeat (15) @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        vectors++;
        if (TIME_BCD !== 16'h0000 || RUNNING !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got %h run=%b exp 0000 run=0", TIME_BCD, RUNNING);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_countdown();
        SW = 8'h59;
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h5900 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b1000) begin
            miscompares++;
            $display("FAIL load59 got %h/%b exp 5900/1000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        repeat (9) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h5900) begin
            miscompares++;
            $display("FAIL pretick got %h exp 5900", TIME_BCD);
        end
        @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h5859) begin
            miscompares++;
            $display("FAIL tick1 got %h exp 5859", TIME_BCD);
        end
        repeat (10) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h5858) begin
            miscompares++;
            $display("FAIL tick2 got %h exp 5858", TIME_BCD);
        end
        press(1);
        vectors++;
        if (TIME_BCD !== 16'h0000 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000) begin
            miscompares++;
            $display("FAIL cancel_run got %h/%b exp 0000/0000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
    endtask

    task automatic test_pause();
        SW = 8'h10;
        press(0);
        repeat (30) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0957) begin
            miscompares++;
            $display("FAIL borrow3 got %h exp 0957", TIME_BCD);
        end
        press(0);
        repeat (50) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0957 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0100) begin
            miscompares++;
            $display("FAIL paused got %h/%b exp 0957/0100", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        press(0);
        repeat (9) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0957 || RUNNING !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_hold got %h run=%b exp 0957 run=1", TIME_BCD, RUNNING);
        end
        @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0956) begin
            miscompares++;
            $display("FAIL resume_tick got %h exp 0956", TIME_BCD);
        end
        press(1);
    endtask

    task automatic test_alarm();
        SW = 8'h01;
        press(0);
        repeat (10) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0059) begin
            miscompares++;
            $display("FAIL borrow_m1 got %h exp 0059", TIME_BCD);
        end
        repeat (589) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0001 || RUNNING !== 1'b1) begin
            miscompares++;
            $display("FAIL last_sec got %h run=%b exp 0001 run=1", TIME_BCD, RUNNING);
        end
        @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0000 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0011) begin
            miscompares++;
            $display("FAIL alarm_entry got %h/%b exp 0000/0011", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        repeat (9) @(negedge CLK);
        vectors++;
        if (BLINK !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_hold got %b exp 1", BLINK);
        end
        @(negedge CLK);
        vectors++;
        if (BLINK !== 1'b0 || TIME_BCD !== 16'h0000) begin
            miscompares++;
            $display("FAIL blink_tog1 got %b/%h exp 0/0000", BLINK, TIME_BCD);
        end
        repeat (10) @(negedge CLK);
        vectors++;
        if (BLINK !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_tog2 got %b exp 1", BLINK);
        end
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h0000 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000) begin
            miscompares++;
            $display("FAIL alarm_ack got %h/%b exp 0000/0000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
    endtask

    task automatic test_load_edge();
        SW = 8'h00;
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h0000 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000) begin
            miscompares++;
            $display("FAIL zero_load got %h/%b exp 0000/0000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        SW = 8'hFA;
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h9900 || RUNNING !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate got %h run=%b exp 9900 run=1", TIME_BCD, RUNNING);
        end
        @(negedge CLK);
        KEY_N = 2'b00;
        repeat (3) @(negedge CLK);
        vectors++;
        if (TIME_BCD !== 16'h0000 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000) begin
            miscompares++;
            $display("FAIL both_keys got %h/%b exp 0000/0000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        KEY_N = 2'b11;
        repeat (5) @(negedge CLK);
        vectors++;
        if ({RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000) begin
            miscompares++;
            $display("FAIL both_after got %b exp 0000", {RUNNING, PAUSED, ALARM, BLINK});
        end
    endtask

    task automatic test_back_to_back();
        SW = 8'h12;
        press(0);
        repeat (6) @(negedge CLK);
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h1159 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0100) begin
            miscompares++;
            $display("FAIL tick_start got %h/%b exp 1159/0100", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
        press(1);
        SW = 8'h01;
        press(0);
        repeat (596) @(negedge CLK);
        press(0);
        vectors++;
        if (TIME_BCD !== 16'h0000 || {RUNNING, PAUSED, ALARM, BLINK} !== 4'b0011) begin
            miscompares++;
            $display("FAIL zero_beats_start got %h/%b exp 0000/0011", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
    endtask

    // Entered with the DUT freshly in ALARM (from test_back_to_back)
    task automatic test_alarm_timeout();
`ifdef ALARM_TIMEOUT_EN
        repeat (29) @(negedge CLK);
        vectors++;
        if (ALARM !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early got %b exp 1", ALARM);
        end
        @(negedge CLK);
        vectors++;
        if ({RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000 || TIME_BCD !== 16'h0000) begin
            miscompares++;
            $display("FAIL timeout_clear got %h/%b exp 0000/0000", TIME_BCD, {RUNNING, PAUSED, ALARM, BLINK});
        end
`else
        repeat (100) @(negedge CLK);
        vectors++;
        if (ALARM !== 1'b1) begin
            miscompares++;
            $display("FAIL alarm_persist got %b exp 1", ALARM);
        end
        press(1);
        vectors++;
        if ({RUNNING, PAUSED, ALARM, BLINK} !== 4'b0000) begin
            miscompares++;
            $display("FAIL alarm_cancel got %b exp 0000", {RUNNING, PAUSED, ALARM, BLINK});
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_async_reset();
        test_countdown();
        test_pause();
        test_alarm();
        test_load_edge();
        test_back_to_back();
        test_alarm_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
